tt_um_serial_sub: RTL and testbench
===================================

Name: tt_um_serial_sub

Overview:
- Bit-serial subtractor (A − B) for the Tiny Tapeout user slot. It is the inverse-direction companion of the team's combinational half adder.
- Operand bits arrive LSB-first, one pair per accepted beat. Bit 0 uses a half-subtractor; later bits use a full-subtractor with a registered borrow.
- Emits each difference bit serially and assembles the parallel result, final borrow, zero flag and frame-length error at frame end.

Parameters:
- WIDTH, 8, maximum operand bits stored per frame; legal range 2..8, result presented on uio_out[WIDTH-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; when low, all registers hold.
- ui_in  input  8  [0]=a bit, [1]=b bit, [2]=in_valid, [3]=in_last, [7:4] unused.
- uo_out  output  8  [0]=diff bit, [1]=borrow_out, [2]=out_valid, [3]=done, [4]=zero, [5]=len_err, [6]=signed_ovf, [7]=0.
- uio_in  input  8  unused.
- uio_out  output  8  parallel result; bits above WIDTH-1 are 0.
- uio_oe  output  8  constant 8'hFF.

Behaviour:
- Reset (async assert, sync release): all uo_out bits 0, uio_out 0, borrow register 0, bit counter 0, state IDLE.
- Beat accepted at a rising edge when ena=1 and in_valid=1. No backpressure; every valid beat is consumed.
- ena=0: no state changes; outputs hold their previous values, including pulse outputs.
- Per-beat arithmetic (bin=0 in IDLE, else borrow register):
  - d = a^b^bin
  - bout = (~a&b) | (~(a^b)&bin)
- Latency: one cycle. d appears on uo_out[0] with out_valid=1 in the cycle after the accepting edge. out_valid is 0 after any edge with no accepted beat. uo_out[0] holds its last value when out_valid=0.
- FSM IDLE:
  - Accepted beat: clear result, zero-tracking, len_err and signed_ovf; store d at result[0]; count=1.
  - If in_last=0, go to RUN; if in_last=1, complete the frame in place (single-bit frame).
- FSM RUN: accepted beat stores d at result[count] if count<WIDTH; count increments, saturating at WIDTH.
  - Beat arriving when count==WIDTH: len_err set (sticky to frame end); d still output serially but not stored; borrow still propagates.
- Frame completion (accepted beat with in_last=1):
  - Next cycle: done=1 for exactly one cycle (same cycle as the final out_valid).
  - borrow_out = bout of the last beat; zero = 1 iff every stored d was 0.
  - State returns to IDLE, borrow register cleared.
- Between frames: uio_out, borrow_out, zero, len_err and signed_ovf hold frame results until the first beat of the next frame.
- in_valid=0 mid-frame: gap cycle, state unchanged.
- Reset mid-frame: frame discarded, all outputs to reset values immediately.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_EN.
- When defined:
  - Registers a, b and d of the last beat.
  - At frame completion, signed_ovf = (a^b)&(a^d), the two's-complement overflow of the last beat.
  - Updates with done; cleared at frame start.
- When undefined: uo_out[6] tied 0 and no extra registers are built.

Test Plan:
- 8-beat frame A=0x05, B=0x03 → serial d=0,1,0,0,0,0,0,0; at done uio_out=0x02, borrow_out=0, zero=0, len_err=0.
- A=0x03, B=0x05 → uio_out=0xFE, borrow_out=1, zero=0.
- A=0x5A, B=0x5A → uio_out=0x00, zero=1, borrow_out=0. Then A=0x80, B=0x01 → uio_out=0x7F, signed_ovf=1 with macro, 0 without.
- 9-beat frame, all bits a=1, b=0 → len_err=1 at done, uio_out=0xFF, nine out_valid pulses.
- Frame with in_valid gaps and ena held low for 3 cycles mid-frame → result identical to the gap-free run; no outputs change while ena=0.
- rst_n pulsed low after beat 4 of A=0x0F, B=0x01 → all outputs 0 at once. A following full frame A=0x10, B=0x01 → uio_out=0x0F, borrow_out=0.

Source files
------------

// File: rtl/tt_um_serial_sub.sv
// Bit-serial subtractor (A - B), operands LSB-first, one bit pair per accepted beat.
// Optional signed overflow flag on uo_out[6] when SERIAL_SUB_SIGNED_EN is defined.
module tt_um_serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         state_q, state_d;
    logic           borrow_q, borrow_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic           zero_trk_q, zero_trk_d;
    logic           zero_q, zero_d;
    logic           len_err_q, len_err_d;
    logic           borrow_out_q, borrow_out_d;
    logic           diff_q, diff_d;
    logic           out_valid_q, out_valid_d;
    logic           done_q, done_d;
    logic           sov;

    logic a, b, accept, last, bin, d, bout;

    assign a      = ui_in[0];
    assign b      = ui_in[1];
    assign accept = ui_in[2];
    assign last   = ui_in[3];
    assign bin    = (state_q == S_RUN) ? borrow_q : 1'b0;
    assign d      = a ^ b ^ bin;
    assign bout   = (~a & b) | (~(a ^ b) & bin);

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = last ? S_IDLE : S_RUN;
        end
    end

    // Datapath and frame flags; registers only advance while ena is high.
    always_comb begin
        borrow_d     = borrow_q;
        count_d      = count_q;
        result_d     = result_q;
        zero_trk_d   = zero_trk_q;
        zero_d       = zero_q;
        len_err_d    = len_err_q;
        borrow_out_d = borrow_out_q;
        diff_d       = diff_q;
        out_valid_d  = 1'b0;
        done_d       = 1'b0;
        if (accept) begin
            diff_d      = d;
            out_valid_d = 1'b1;
            done_d      = last;
            borrow_d    = last ? 1'b0 : bout;
            if (state_q == S_IDLE) begin
                result_d     = '0;
                result_d[0]  = d;
                zero_trk_d   = ~d;
                zero_d       = 1'b0;
                len_err_d    = 1'b0;
                borrow_out_d = 1'b0;
                count_d      = CW'(1);
            end else if (count_q < CW'(WIDTH)) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (count_q == CW'(i)) result_d[i] = d;
                end
                zero_trk_d = zero_trk_q & ~d;
                count_d    = count_q + CW'(1);
            end else begin
                len_err_d = 1'b1;
            end
            if (last) begin
                borrow_out_d = bout;
                zero_d       = zero_trk_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_q     <= 1'b0;
            count_q      <= '0;
            result_q     <= '0;
            zero_trk_q   <= 1'b0;
            zero_q       <= 1'b0;
            len_err_q    <= 1'b0;
            borrow_out_q <= 1'b0;
            diff_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else if (ena) begin
            borrow_q     <= borrow_d;
            count_q      <= count_d;
            result_q     <= result_d;
            zero_trk_q   <= zero_trk_d;
            zero_q       <= zero_d;
            len_err_q    <= len_err_d;
            borrow_out_q <= borrow_out_d;
            diff_q       <= diff_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef SERIAL_SUB_SIGNED_EN
    // Overflow is derived from the last beat's bits, valid only once the frame completes.
    logic last_a_q, last_a_d, last_b_q, last_b_d, last_d_q, last_d_d;
    logic sov_flag_q, sov_flag_d;

    always_comb begin
        last_a_d   = accept ? a : last_a_q;
        last_b_d   = accept ? b : last_b_q;
        last_d_d   = accept ? d : last_d_q;
        sov_flag_d = accept ? last : sov_flag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a_q   <= 1'b0;
            last_b_q   <= 1'b0;
            last_d_q   <= 1'b0;
            sov_flag_q <= 1'b0;
        end else if (ena) begin
            last_a_q   <= last_a_d;
            last_b_q   <= last_b_d;
            last_d_q   <= last_d_d;
            sov_flag_q <= sov_flag_d;
        end
    end

    assign sov = sov_flag_q & (last_a_q ^ last_b_q) & (last_a_q ^ last_d_q);
`else
    assign sov = 1'b0;
`endif

    always_comb begin
        uo_out  = {1'b0, sov, len_err_q, zero_q, done_q, out_valid_q, borrow_out_q, diff_q};
        uio_out = 8'(result_q);
        uio_oe  = 8'hFF;
    end
endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Randomized and directed bench for tt_um_serial_sub against an arithmetic reference model.
module tb_tt_um_serial_sub;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tt_um_serial_sub dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit a, input bit b, input bit last);
        ui_in = {4'h0, last, v, b, a};
    endtask

    // Model: n-bit unsigned subtraction; only the low 8 difference bits are stored.
    task automatic run_frame(input logic [31:0] A, input logic [31:0] B, input int n,
                             input int gap_pct, input bit pause);
        logic [31:0] mask, ea, eb, diff, stored;
        logic        e_borrow, e_zero, e_len, e_ovf;
        logic [7:0]  snap_uo, snap_uio;
        int          pause_at;
        mask     = (32'd1 << n) - 32'd1;
        ea       = A & mask;
        eb       = B & mask;
        diff     = (ea - eb) & mask;
        stored   = diff & 32'hFF;
        e_borrow = ea < eb;
        e_zero   = (stored == 0);
        e_len    = n > 8;
`ifdef SERIAL_SUB_SIGNED_EN
        e_ovf    = (ea[n-1] != eb[n-1]) && (diff[n-1] != ea[n-1]);
`else
        e_ovf    = 1'b0;
`endif
        pause_at = pause ? int'($urandom_range(n - 1, 0)) : -1;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                @(posedge clk); @(negedge clk);
                check("gap_valid", 32'(uo_out[2]), 32'd0);
            end
            drive(1'b1, ea[i], eb[i], i == n - 1);
            @(posedge clk); @(negedge clk);
            check("out_valid", 32'(uo_out[2]), 32'd1);
            check("diff_bit", 32'(uo_out[0]), 32'(diff[i]));
            check("done", 32'(uo_out[3]), 32'(i == n - 1));
            if (i == n - 1) begin
                check("result", 32'(uio_out), stored);
                check("borrow_out", 32'(uo_out[1]), 32'(e_borrow));
                check("zero", 32'(uo_out[4]), 32'(e_zero));
                check("len_err", 32'(uo_out[5]), 32'(e_len));
                check("signed_ovf", 32'(uo_out[6]), 32'(e_ovf));
                check("bit7", 32'(uo_out[7]), 32'd0);
            end
            if (i == pause_at) begin
                snap_uo  = uo_out;
                snap_uio = uio_out;
                ena = 1'b0;
                drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
                repeat (3) begin
                    @(posedge clk); @(negedge clk);
                    check("hold_uo", 32'(uo_out), 32'(snap_uo));
                    check("hold_uio", 32'(uio_out), 32'(snap_uio));
                end
                ena = 1'b1;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("idle_valid", 32'(uo_out[2]), 32'd0);
        check("idle_done", 32'(uo_out[3]), 32'd0);
        check("idle_result", 32'(uio_out), stored);
        check("idle_borrow", 32'(uo_out[1]), 32'(e_borrow));
        check("idle_zero", 32'(uo_out[4]), 32'(e_zero));
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_uo", 32'(uo_out), 32'd0);
        check("rst_uio", 32'(uio_out), 32'd0);
        check("uio_oe", 32'(uio_oe), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(32'h05, 32'h03, 8, 0, 1'b0);
        run_frame(32'h03, 32'h05, 8, 0, 1'b0);
        run_frame(32'h5A, 32'h5A, 8, 0, 1'b0);
        run_frame(32'h80, 32'h01, 8, 0, 1'b0);
        run_frame(32'h1FF, 32'h000, 9, 0, 1'b0);
        run_frame(32'h05, 32'h03, 8, 40, 1'b1);
        run_frame(32'h00, 32'h01, 1, 0, 1'b0);

        // Reset four beats into a frame, then a clean frame must not see stale borrow.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, i == 0, 1'b0);
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_uo", 32'(uo_out), 32'd0);
        check("midrst_uio", 32'(uio_out), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(32'h10, 32'h01, 8, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_frame($urandom, $urandom, int'($urandom_range(11, 1)),
                      int'($urandom_range(30, 0)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
